// File: rtl/data_mem_resp_if.sv
// Request/response bus between the CPU load/store port and the data-memory responder.
//   master : CPU side   - drives req_valid/req_write/req_addr/req_wdata
//   slave  : responder  - drives req_ready/resp_valid/resp_rdata/resp_err/busy
interface data_mem_resp_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16
);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              busy;

  modport master (
    output req_valid,
    output req_write,
    output req_addr,
    output req_wdata,
    input  req_ready,
    input  resp_valid,
    input  resp_rdata,
    input  resp_err,
    input  busy
  );

  modport slave (
    input  req_valid,
    input  req_write,
    input  req_addr,
    input  req_wdata,
    output req_ready,
    output resp_valid,
    output resp_rdata,
    output resp_err,
    output busy
  );

endinterface

// File: rtl/data_mem_resp.sv
// Data-memory responder: serves one word load/store at a time from an internal
// register array, with a fixed access latency and a one-cycle response pulse.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - data_mem_resp_if.slave (request handshake, response, busy)
// Optional feature macro: DATA_MEM_ADDR_ERR_EN
//   defined   : misaligned or out-of-range addresses complete with resp_err=1,
//               resp_rdata=0 and no array write
//   undefined : resp_err is always 0, word index wraps modulo DEPTH
module data_mem_resp #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst,
  data_mem_resp_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(LATENCY) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;

  // Request captured at the accept edge
  logic              write_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic              err_q;

  // Registered outputs
  logic              req_ready_q;
  logic              resp_valid_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic              resp_err_q;
  logic              busy_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  req_idx_c;
  logic              req_err_c;
  logic              commit_c;

  // Word index: byte address with the byte-select bit dropped
  assign req_idx_c = bus.req_addr[IDX_W:1];

`ifdef DATA_MEM_ADDR_ERR_EN
  // Misaligned, or any address bit above the array's word range set
  assign req_err_c = bus.req_addr[0] | ((bus.req_addr >> (IDX_W + 1)) != '0);
`else
  // Byte-select and upper bits are don't-care; indices wrap
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.req_addr[0], bus.req_addr >> (IDX_W + 1)};
  assign req_err_c = 1'b0;
`endif

  // Last ACCESS cycle: the edge that moves to RESP commits the access
  assign commit_c = (state == ACCESS) && (cnt == '0);

  // Array storage, deliberately not reset; reset forces IDLE so no stray commit
  always_ff @(posedge clk) begin
    if (commit_c && write_q && !err_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

  // Control FSM with registered handshake/response outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      write_q      <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= '0;
      err_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          resp_err_q <= 1'b0;
          if (bus.req_valid) begin
            write_q     <= bus.req_write;
            idx_q       <= req_idx_c;
            wdata_q     <= bus.req_wdata;
            err_q       <= req_err_c;
            cnt         <= CNT_LOAD;
            state       <= ACCESS;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end

        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            state        <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= err_q;
            // Stores and errored requests return zero data
            resp_rdata_q <= (write_q || err_q) ? '0 : mem[idx_q];
          end
        end

        RESP: begin
          state        <= IDLE;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          req_ready_q  <= 1'b1;
          busy_q       <= 1'b0;
        end

        default: begin
          state        <= IDLE;
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Scoreboard bench for data_mem_resp (DEPTH=256, LATENCY=2).
module tb_data_mem_resp;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;

  logic [16:0] sb[$];   // {resp_err, resp_rdata}
  logic [16:0] exp_e;
  int          acc1;
  int          acc2;

  data_mem_resp_if #(.DATA_W(16), .ADDR_W(16)) bus ();

  data_mem_resp #(
    .DATA_W(16), .ADDR_W(16), .DEPTH(256), .LATENCY(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every response pulse
  always @(negedge clk) begin
    if (rst === 1'b1 && bus.resp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got resp_valid=1 rdata=0x%0h expected no response", bus.resp_rdata);
      end else begin
        exp_e = sb.pop_front();
        chk("resp_rdata", 32'(bus.resp_rdata), 32'(exp_e[15:0]));
        chk("resp_err", 32'(bus.resp_err), 32'(exp_e[16]));
      end
    end
  end

  // Present a request and hold it until accepted; returns just after the accept edge
  task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d,
                       input bit push, input logic [15:0] er, input logic ee,
                       output int acc);
    int n;
    n = 0;
    acc = -1;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    while (bus.req_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got req_ready=0 for 40 cycles expected accept");
    end else begin
      if (push) sb.push_back({ee, er});
      acc = cyc + 1;
    end
    @(posedge clk);
  endtask

  // Drop the request and wait for all outstanding responses
  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    while ((sb.size() != 0 || bus.req_ready !== 1'b1) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
    chk({tag, "_resp_rdata"}, 32'(bus.resp_rdata), 32'h0);
    chk({tag, "_resp_err"}, 32'(bus.resp_err), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    rst = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("por");
    rst = 1'b1;

    // Store then load, with cycle-accurate handshake timing
    issue(1'b1, 16'h0010, 16'h1234, 1'b1, 16'h0000, 1'b0, acc1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("t1_ready", 32'(bus.req_ready), 32'd0);
    chk("t1_busy", 32'(bus.busy), 32'd1);
    chk("t1_valid", 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    chk("t2_ready", 32'(bus.req_ready), 32'd0);
    chk("t2_valid", 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    chk("t3_ready", 32'(bus.req_ready), 32'd0);
    chk("t3_valid", 32'(bus.resp_valid), 32'd1);
    @(negedge clk);
    chk("t4_ready", 32'(bus.req_ready), 32'd1);
    chk("t4_valid", 32'(bus.resp_valid), 32'd0);
    chk("t4_busy", 32'(bus.busy), 32'd0);
    issue(1'b0, 16'h0010, 16'h0000, 1'b1, 16'h1234, 1'b0, acc1);
    drain();

    // Asynchronous reset mid-ACCESS with non-zero resp_rdata held
    issue(1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000, 1'b0, acc1);
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b1;

    // Continuous req_valid: store then load, back-to-back accepts
    issue(1'b1, 16'h0004, 16'hC0DE, 1'b1, 16'h0000, 1'b0, acc1);
    issue(1'b0, 16'h0004, 16'h0000, 1'b1, 16'hC0DE, 1'b0, acc2);
    chk("accept_spacing", 32'(acc2 - acc1), 32'd4);
    drain();

    // Store aborted by reset in ACCESS is not committed
    issue(1'b1, 16'h0020, 16'h1111, 1'b1, 16'h0000, 1'b0, acc1);
    drain();
    issue(1'b1, 16'h0020, 16'hBEEF, 1'b0, 16'h0000, 1'b0, acc1);
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    issue(1'b0, 16'h0020, 16'h0000, 1'b1, 16'h1111, 1'b0, acc1);
    drain();

`ifdef DATA_MEM_ADDR_ERR_EN
    // Address errors: misaligned and out of range, no array write
    issue(1'b1, 16'h0002, 16'h7777, 1'b1, 16'h0000, 1'b0, acc1);
    drain();
    issue(1'b1, 16'h0203, 16'h1357, 1'b1, 16'h0000, 1'b1, acc1);
    drain();
    chk("err_clear_idle", 32'(bus.resp_err), 32'd0);
    issue(1'b1, 16'h0202, 16'h5555, 1'b1, 16'h0000, 1'b1, acc1);
    drain();
    issue(1'b0, 16'h0002, 16'h0000, 1'b1, 16'h7777, 1'b0, acc1);
    drain();
`else
    // Index wrap: upper address bits ignored
    issue(1'b1, 16'h0202, 16'hAAAA, 1'b1, 16'h0000, 1'b0, acc1);
    drain();
    issue(1'b0, 16'h0002, 16'h0000, 1'b1, 16'hAAAA, 1'b0, acc1);
    drain();
`endif

    // Requests presented while busy are ignored
    issue(1'b1, 16'h0030, 16'h2222, 1'b1, 16'h0000, 1'b0, acc1);
    drain();
    issue(1'b0, 16'h0030, 16'h0000, 1'b1, 16'h2222, 1'b0, acc1);
    @(negedge clk);
    bus.req_write = 1'b1;
    bus.req_wdata = 16'h9999;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    drain();
    repeat (3) @(negedge clk);
    issue(1'b0, 16'h0030, 16'h0000, 1'b1, 16'h2222, 1'b0, acc1);
    drain();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/data_mem_resp.md
Name: data_mem_resp

Overview:
- Data-memory responder on the far side of the CPU load/store port: it serves the requests the datapath raises through its mem_read/mem_write controls.
- Accepts one 16-bit word request at a time over a valid/ready handshake.
- Services each request in a configurable number of cycles and returns a one-cycle response pulse.
- The CPU stalls on busy. Memory is an internal register array.

Parameters:
- DATA_W, 16: data word width.
- ADDR_W, 16: byte-address width of req_addr.
- DEPTH, 256: number of words in the array (power of 2).
- LATENCY, 2: cycles spent in ACCESS (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- req_valid  input  1  CPU request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  ADDR_W  byte address; word index = req_addr[log2(DEPTH):1].
- req_wdata  input  DATA_W  store data.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  DATA_W  load data, valid with resp_valid.
- resp_err  output  1  address error flag, valid with resp_valid.
- busy  output  1  high when state != IDLE.

Behaviour:
- States: IDLE, ACCESS, RESP. Counter cnt is log2(LATENCY)+1 bits.
- Reset (rst=0, asynchronous):
  - State goes to IDLE and cnt to 0.
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, busy=0.
  - Array contents are not reset.
- IDLE:
  - req_ready=1.
  - On an edge with req_valid=1, latch req_write, req_addr and req_wdata, load cnt=LATENCY-1, go to ACCESS.
  - req_ready and busy change on that same edge.
- ACCESS:
  - req_ready=0. If cnt!=0, decrement cnt.
  - If cnt==0, go to RESP on that edge. A store writes mem[idx]<=wdata on that edge. A load captures resp_rdata<=mem[idx] on that edge.
  - For a store, resp_rdata<=0.
- RESP:
  - resp_valid=1 for exactly one cycle. No backpressure.
  - Go to IDLE on the next edge. resp_valid falls on that edge; resp_rdata holds until the next completion.
- Timing: a request accepted at edge T makes resp_valid high after edge T+LATENCY. req_ready returns after edge T+LATENCY+1. The earliest next accept is edge T+LATENCY+2.
- req_valid while req_ready=0 is ignored, with no queueing; the CPU holds the request until accepted. Inputs are sampled only at the accept edge.
- Read-after-write: a load following a completed store to the same word returns the stored value.
- Reset mid-ACCESS: the request is aborted. A store is not committed unless its commit edge occurred before rst fell.
- Without ADDR_ERR_EN, idx wraps modulo DEPTH and upper address bits are ignored.

Optional Feature:
- Macro: DATA_MEM_ADDR_ERR_EN.
- Defined:
  - At accept, flag the request as an error if req_addr[0]==1 (misaligned) or req_addr[ADDR_W-1:log2(DEPTH)+1]!=0 (out of range).
  - An errored request takes the same latency path, performs no array write, and returns resp_rdata=0 with resp_err=1 alongside resp_valid.
  - resp_err clears in IDLE.
- Undefined:
  - resp_err is tied to 0 and req_addr[0] is ignored.
  - Indices wrap as described above.

Test Plan (DEPTH=256, LATENCY=2):
1. Hold rst=0 mid-simulation -> immediately req_ready=1, busy=0, resp_valid=0, resp_rdata=0x0000, resp_err=0.
2. Store 0x1234 @0x0010 accepted at edge T -> resp_valid high only after T+2, req_ready low for 3 cycles. Then load @0x0010 -> resp_rdata=0x1234.
3. Keep req_valid high continuously with a store @0x0004 followed by a load @0x0004 -> second accept exactly 4 edges after the first, load returns the stored value.
4. Preload 0x1111 @0x0020. Issue store 0xBEEF @0x0020, pulse rst low one cycle after accept (in ACCESS) -> a later load @0x0020 returns 0x1111.
5. Macro undefined: store 0xAAAA @0x0202 -> load @0x0002 returns 0xAAAA (wrap), resp_err=0. Macro defined: store @0x0203 -> resp_err=1, resp_rdata=0. Store @0x0202 -> resp_err=1, and a load @0x0002 is unchanged.
6. While busy, toggle req_valid with a different addr/wdata -> ignored: no extra resp_valid, memory unchanged, original response data correct.
